// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding, vector count
// and dwell counter width.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned VEC_W       = $clog2(NUM_VECTORS);
  localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each dwell
// period, wrapping to zero on its own at that point.
module dwell_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_terminal = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (i_enable && o_terminal)) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 input vectors of an external 4-input function, holds each for
// DWELL cycles, captures F into a table and compares it with a golden table.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NUM_VECTORS-1:0] i_expected,
  input  logic                   i_f_in,
  output logic [VEC_W-1:0]       o_abcd,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NUM_VECTORS-1:0] o_table,
  output logic                   o_match
);

  state_t                 r_state;
  state_t                 w_next;
  logic [VEC_W-1:0]       r_vec;
  logic [NUM_VECTORS-1:0] r_table;
  logic [NUM_VECTORS-1:0] w_table_next;
  logic                   r_match;
  logic                   w_accept;
  logic                   w_sample;
  logic                   w_abort_run;
  logic                   w_terminal;
  logic                   w_last;
  logic                   w_tmr_clear;
  logic                   w_tmr_en;

  assign w_last      = (r_vec == VEC_W'(NUM_VECTORS - 1));
  assign w_tmr_en    = (r_state == ST_RUN);
  assign w_tmr_clear = (r_state != ST_RUN) || i_abort;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_terminal(w_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_abort_run = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (i_abort) begin
          w_abort_run = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_terminal) begin
          w_sample = 1'b1;
          if (w_last) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Match must see the bit being captured on the same edge, so compare the merged table.
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = i_f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec   <= '0;
      r_table <= '0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_vec   <= '0;
      r_table <= '0;
      r_match <= 1'b0;
    end else if (w_abort_run) begin
      r_match <= 1'b0;
    end else if (w_sample) begin
      r_table <= w_table_next;
      if (w_last) begin
        r_match <= (w_table_next == i_expected);
      end else begin
        r_vec <= r_vec + 1'b1;
      end
    end
  end

  assign o_abcd  = r_vec;
  assign o_table = r_table;
  assign o_match = r_match;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized scoreboard bench: expected sweep results are queued at start and
// checked by an independent monitor whenever done pulses.
module tb_truth_table_sequencer;

  localparam int D = 4;

  typedef struct {
    logic [15:0] tbl;
    logic        m;
    int          e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [15:0] i_expected = 16'h0;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy, done, match;
  logic [15:0] tbl;

  logic        s1_start = 1'b0;
  logic        f1_in;
  logic [3:0]  abcd1;
  logic        busy1, done1, match1;
  logic [15:0] tbl1;

  logic [15:0] fut_tt = 16'hF888;
  int          edge_n = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Function under test modelled directly as its truth table.
  assign f_in  = fut_tt[abcd];
  assign f1_in = fut_tt[abcd1];

  truth_table_sequencer #(.DWELL(D)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_expected(i_expected), .i_f_in(f_in), .o_abcd(abcd), .o_busy(busy),
    .o_done(done), .o_table(tbl), .o_match(match)
  );

  truth_table_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(s1_start), .i_abort(1'b0),
    .i_expected(16'hF888), .i_f_in(f1_in), .o_abcd(abcd1), .o_busy(busy1),
    .o_done(done1), .o_table(tbl1), .o_match(match1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done at edge %0d", edge_n);
      end else begin
        e = sb.pop_front();
        chk("done_table", 32'(tbl), 32'(e.tbl));
        chk("done_match", 32'(match), 32'(e.m));
        chk("done_edge", 32'(edge_n), 32'(e.e));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic sweep(input logic [15:0] tt, input logic [15:0] expf,
                       input bit chg, input bit poke);
    int k;
    fut_tt     = tt;
    i_expected = chg ? 16'($urandom) : expf;
    i_start    = 1'b1;
    k          = edge_n + 1;
    sb.push_back('{tbl: tt, m: (tt == expf), e: k + 16 * D});
    tick();
    i_start = 1'b0;
    chk("busy_on_accept", 32'(busy), 32'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      i_start = (poke && c == 10);
    end
    i_start    = 1'b0;
    i_expected = expf;
    drain(16 * D + 10);
  endtask

  initial begin
    int n;
    int k;
    logic [15:0] tt;
    logic [15:0] ex;
    int mode;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_table", 32'(tbl), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_abcd", 32'(abcd), 32'd0);
    tick();
    rst = 1'b0;

    sweep(16'hF888, 16'hF888, 1'b0, 1'b0);
    sweep(16'hF888, 16'hF889, 1'b0, 1'b1);

    for (int s = 0; s < 8; s++) begin
      tt   = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)      ex = tt;
      else if (mode == 1) ex = tt ^ (16'h1 << $urandom_range(0, 15));
      else                ex = 16'($urandom);
      sweep(tt, ex, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    tick();
    chk("idle_abcd_holds_last", 32'(abcd), 32'd15);

    // Abort while vector 5 is applied.
    fut_tt     = 16'hF888;
    i_expected = 16'hF888;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (abcd != 4'd5 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reach_vec5", 32'(abcd), 32'd5);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_match", 32'(match), 32'd0);
    chk("abort_table", 32'(tbl), 32'(fut_tt & 16'((1 << 5) - 1)));
    repeat (80) tick();

    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    chk("start_abort_busy0", 32'(busy), 32'd0);
    tick();
    chk("start_abort_busy1", 32'(busy), 32'd0);
    i_start = 1'b0;
    i_abort = 1'b0;

    // DWELL=1 instance latency.
    fut_tt   = 16'hF888;
    s1_start = 1'b1;
    k        = edge_n + 1;
    tick();
    s1_start = 1'b0;
    n = 0;
    while (!done1 && n < 40) begin
      tick();
      n++;
    end
    chk("d1_done_seen", 32'(done1), 32'd1);
    chk("d1_done_edge", 32'(edge_n - k), 32'd16);
    chk("d1_table", 32'(tbl1), 32'(fut_tt));
    chk("d1_match", 32'(match1), 32'd1);
    chk("d1_busy", 32'(busy1), 32'd0);

    // Back-to-back with start held, then reset inside the second sweep.
    tt         = 16'($urandom);
    fut_tt     = tt;
    i_expected = tt;
    i_start    = 1'b1;
    k          = edge_n + 1;
    sb.push_back('{tbl: tt, m: 1'b1, e: k + 16 * D});
    repeat (k + 16 * D + 1 - edge_n) tick();
    chk("b2b_idle_gap", 32'(busy), 32'd0);
    tick();
    chk("b2b_second_accept", 32'(busy), 32'd1);
    chk("b2b_first_done_seen", 32'(sb.size()), 32'd0);
    repeat (10) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_table", 32'(tbl), 32'd0);
    chk("mid_rst_match", 32'(match), 32'd0);
    chk("mid_rst_abcd", 32'(abcd), 32'd0);
    i_start = 1'b0;
    tick();
    rst = 1'b0;
    repeat (80) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
